// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: widths, halt opcode and the fetch state encoding.
package cpu_pkg;

    localparam int ADDR_W = 3;
    localparam int INST_W = 8;
    localparam logic [INST_W-1:0] HALT_OPCODE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch unit bus: instruction memory address/data, control inputs and the decode handshake.
interface inst_fetch_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int INST_W = cpu_pkg::INST_W
);

    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_inst;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              out_valid;
    logic              out_ready;
    logic              halted;

    // master is the fetch unit; slave is the surrounding core/memory/decode side
    modport master (
        input  start, imem_inst, redirect, redirect_pc, out_ready,
        output imem_addr, out_inst, out_pc, out_valid, halted
    );

    modport slave (
        output start, imem_inst, redirect, redirect_pc, out_ready,
        input  imem_addr, out_inst, out_pc, out_valid, halted
    );

endinterface

// File: rtl/fetch_pc.sv
// Program counter: load has priority over increment; increment wraps modulo 2^ADDR_W.
module fetch_pc #(
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_pc,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, output register, decode handshake and fetch FSM.
// Optional halt-opcode detection is enabled by defining INST_FETCH_HALT_EN.
module inst_fetch #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int INST_W = cpu_pkg::INST_W
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    import cpu_pkg::*;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic              r_out_valid;
    logic              w_out_valid_nxt;
    logic [INST_W-1:0] r_out_inst;
    logic [ADDR_W-1:0] r_out_pc;

    logic [ADDR_W-1:0] w_pc;
    logic              w_pc_load;
    logic [ADDR_W-1:0] w_pc_load_val;
    logic              w_pc_inc;
    logic              w_capture;
    logic              w_is_halt;

`ifdef INST_FETCH_HALT_EN
    assign w_is_halt  = (bus.imem_inst == HALT_OPCODE);
    assign bus.halted = (r_state == HALTED);
`else
    assign w_is_halt  = 1'b0;
    assign bus.halted = 1'b0;
`endif

    fetch_pc #(.ADDR_W(ADDR_W)) u_fetch_pc (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_pc_load),
        .i_load_pc (w_pc_load_val),
        .i_inc     (w_pc_inc),
        .o_pc      (w_pc)
    );

    // start beats redirect beats capture; a redirect in IDLE has no effect
    always_comb begin
        w_state_nxt     = r_state;
        w_out_valid_nxt = r_out_valid;
        w_pc_load       = 1'b0;
        w_pc_load_val   = '0;
        w_pc_inc        = 1'b0;
        w_capture       = 1'b0;

        if (bus.start) begin
            w_state_nxt     = FETCH;
            w_out_valid_nxt = 1'b0;
            w_pc_load       = 1'b1;
        end else if (bus.redirect && (r_state != IDLE)) begin
            w_state_nxt     = FETCH;
            w_out_valid_nxt = 1'b0;
            w_pc_load       = 1'b1;
            w_pc_load_val   = bus.redirect_pc;
        end else if ((r_state == FETCH) && (!r_out_valid || bus.out_ready)) begin
            w_capture       = 1'b1;
            w_out_valid_nxt = 1'b1;
            if (w_is_halt) begin
                w_state_nxt = HALTED;
            end else begin
                w_pc_inc    = 1'b1;
            end
        end else if (r_out_valid && bus.out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_inst <= '0;
            r_out_pc   <= '0;
        end else if (w_capture) begin
            r_out_inst <= bus.imem_inst;
            r_out_pc   <= w_pc;
        end
    end

    assign bus.imem_addr = w_pc;
    assign bus.out_inst  = r_out_inst;
    assign bus.out_pc    = r_out_pc;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch with an 8-entry combinational instruction memory.
module tb_inst_fetch;

    typedef struct packed {
        logic [2:0] pc;
        logic [7:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] mem [8];
    exp_t sb[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(3), .INST_W(8)) bus ();

    inst_fetch #(.ADDR_W(3), .INST_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial mem = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h0F, 8'h5A, 8'hA5, 8'hF0};
    assign bus.imem_inst = mem[bus.imem_addr];

    task automatic push_exp(input logic [2:0] a);
        sb.push_back({a, mem[a]});
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 3'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.out_valid, bus.out_inst, bus.out_pc, bus.imem_addr, bus.halted} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_vals: valid=%b inst=%h pc=%0d addr=%0d halted=%b, required all 0",
                     bus.out_valid, bus.out_inst, bus.out_pc, bus.imem_addr, bus.halted);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== 3'd0) begin
            n_err++;
            $display("FAIL idle_no_fetch: valid=%b addr=%0d, required 0/0", bus.out_valid, bus.imem_addr);
        end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
`ifdef INST_FETCH_HALT_EN
        for (int a = 0; a < 4; a++) push_exp(3'(a));
`else
        for (int a = 0; a < 9; a++) push_exp(3'(a % 8));
`endif
        do_start();
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL start_latency: out_valid=%b one cycle after start, required 0", bus.out_valid);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_extra: got pc=%0d inst=%h, required none", bus.out_pc, bus.out_inst);
                end else begin
                    e = sb.pop_front();
                    if ({bus.out_pc, bus.out_inst} !== e) begin
                        n_err++;
                        $display("FAIL stream_data: got pc=%0d inst=%h, required pc=%0d inst=%h",
                                 bus.out_pc, bus.out_inst, e.pc, e.inst);
                    end
                end
            end else begin
                n_vec++;
                n_err++;
                $display("FAIL stream_bubble: out_valid=%b during full-rate stream, required 1", bus.out_valid);
            end
            if (sb.size() == 0) break;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL stream_timeout: %0d items outstanding, required 0", sb.size());
            sb.delete();
        end
`ifdef INST_FETCH_HALT_EN
        repeat (2) begin
            @(negedge clk);
            n_vec++;
            if (bus.out_valid !== 1'b0 || bus.halted !== 1'b1 || bus.imem_addr !== 3'd3) begin
                n_err++;
                $display("FAIL halt_state: valid=%b halted=%b addr=%0d, required 0/1/3",
                         bus.out_valid, bus.halted, bus.imem_addr);
            end
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 3'd4;
        push_exp(3'd4);
        @(negedge clk);
        bus.redirect = 1'b0;
        @(negedge clk);
        n_vec++;
        e = sb.pop_front();
        if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_inst} !== e || bus.halted !== 1'b0) begin
            n_err++;
            $display("FAIL halt_exit: valid=%b pc=%0d inst=%h halted=%b, required 1/%0d/%h/0",
                     bus.out_valid, bus.out_pc, bus.out_inst, bus.halted, e.pc, e.inst);
        end
        bus.out_ready = 1'b0;
`else
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_vec++;
        if (bus.halted !== 1'b0) begin
            n_err++;
            $display("FAIL halted_tied: halted=%b, required 0", bus.halted);
        end
`endif
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        for (int a = 0; a < 3; a++) push_exp(3'(a));
        do_start();
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                bus.out_ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    n_vec++;
                    if (bus.out_valid !== 1'b1 || bus.out_inst !== 8'h55 || bus.out_pc !== 3'd1 || bus.imem_addr !== 3'd2) begin
                        n_err++;
                        $display("FAIL stall_hold: valid=%b inst=%h pc=%0d addr=%0d, required 1/55/1/2",
                                 bus.out_valid, bus.out_inst, bus.out_pc, bus.imem_addr);
                    end
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
            n_vec++;
            e = sb.pop_front();
            if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_inst} !== e) begin
                n_err++;
                $display("FAIL stall_data: valid=%b pc=%0d inst=%h, required 1/%0d/%h",
                         bus.out_valid, bus.out_pc, bus.out_inst, e.pc, e.inst);
            end
            if (k < 2) @(negedge clk);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_redirect();
        bus.out_ready = 1'b0;
        push_exp(3'd0);
        push_exp(3'd1);
        do_start();
        @(negedge clk);
        bus.out_ready = 1'b1;
        repeat (2) begin
            n_vec++;
            e = sb.pop_front();
            if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_inst} !== e) begin
                n_err++;
                $display("FAIL redir_pre: valid=%b pc=%0d inst=%h, required 1/%0d/%h",
                         bus.out_valid, bus.out_pc, bus.out_inst, e.pc, e.inst);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_inst !== 8'hAA) begin
            n_err++;
            $display("FAIL redir_setup: valid=%b inst=%h, required 1/aa", bus.out_valid, bus.out_inst);
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 3'd5;
        @(negedge clk);
        bus.redirect = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== 3'd5) begin
            n_err++;
            $display("FAIL redir_flush: valid=%b addr=%0d, required 0/5", bus.out_valid, bus.imem_addr);
        end
        push_exp(3'd5);
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        e = sb.pop_front();
        if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_inst} !== e) begin
            n_err++;
            $display("FAIL redir_target: valid=%b pc=%0d inst=%h, required 1/%0d/%h",
                     bus.out_valid, bus.out_pc, bus.out_inst, e.pc, e.inst);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_start_redirect();
        bus.out_ready = 1'b1;
        do_start();
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 3'd6;
        @(negedge clk);
        bus.start = 1'b0;
        bus.redirect = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== 3'd0) begin
            n_err++;
            $display("FAIL start_prio_flush: valid=%b addr=%0d, required 0/0", bus.out_valid, bus.imem_addr);
        end
        push_exp(3'd0);
        @(negedge clk);
        n_vec++;
        e = sb.pop_front();
        if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_inst} !== e) begin
            n_err++;
            $display("FAIL start_prio_data: valid=%b pc=%0d inst=%h, required 1/%0d/%h",
                     bus.out_valid, bus.out_pc, bus.out_inst, e.pc, e.inst);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_async_rst();
        bus.out_ready = 1'b0;
        do_start();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_inst !== 8'h55 || bus.imem_addr !== 3'd2) begin
            n_err++;
            $display("FAIL arst_setup: valid=%b inst=%h addr=%0d, required 1/55/2",
                     bus.out_valid, bus.out_inst, bus.imem_addr);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.out_valid, bus.out_inst, bus.out_pc, bus.imem_addr, bus.halted} !== 15'd0) begin
            n_err++;
            $display("FAIL arst_clear: valid=%b inst=%h pc=%0d addr=%0d halted=%b, required all 0",
                     bus.out_valid, bus.out_inst, bus.out_pc, bus.imem_addr, bus.halted);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 3'd4;
        @(negedge clk);
        bus.redirect = 1'b0;
        repeat (2) begin
            n_vec++;
            if (bus.out_valid !== 1'b0 || bus.imem_addr !== 3'd0) begin
                n_err++;
                $display("FAIL arst_idle: valid=%b addr=%0d, required 0/0", bus.out_valid, bus.imem_addr);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_start_redirect();
        test_async_rst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit driving the address side of the 8-entry instruction memory and presenting fetched instructions to decode. It owns the program counter, issues the read address, captures the combinational read data into an output register, and hands the instruction downstream over a valid/ready handshake. It supports branch redirect, start/restart, and optional halt-opcode detection.

## Interface
- `ADDR_W`, default 3: PC and memory address width (8 entries).
- `INST_W`, default 8: instruction width.
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst` input, 1: reset, asynchronous, active-high.
- `start` input, 1: begin or restart fetching at PC 0.
- `imem_addr` output, ADDR_W: read address to instruction memory; always equals the internal PC register.
- `imem_inst` input, INST_W: combinational read data for `imem_addr`, valid in the same cycle.
- `redirect` input, 1: branch or jump taken.
- `redirect_pc` input, ADDR_W: target address for `redirect`.
- `out_inst` output, INST_W: registered instruction.
- `out_pc` output, ADDR_W: address `out_inst` was fetched from.
- `out_valid` output, 1: `out_inst`/`out_pc` hold an unconsumed instruction.
- `out_ready` input, 1: decode accepts the instruction this cycle.
- `halted` output, 1: high while in state HALTED.

## Operation
- Reset values: `pc`=0, `out_inst`=0, `out_pc`=0, `out_valid`=0, `halted`=0, state IDLE.
- States:
  - IDLE: no fetch.
  - FETCH: fetching.
  - HALTED: no fetch; `halted`=1.
- Event priority each cycle: `start` > `redirect` > capture.
- `start` (any state): `pc`←0, `out_valid`←0, state←FETCH.
- `redirect`:
  - In FETCH or HALTED: `pc`←`redirect_pc`, `out_valid`←0 (flush), state←FETCH.
  - In IDLE: ignored.
- Capture, in FETCH only, when `!out_valid || out_ready`:
  - `out_inst`←`imem_inst`, `out_pc`←`pc`, `out_valid`←1, `pc`←`pc`+1.
- Consume without capture (`out_valid && out_ready`, no capture this cycle): `out_valid`←0.
- PC arithmetic is modulo 2^ADDR_W: 7 wraps to 0, with no flag.
- Stall: while `out_valid && !out_ready`, `pc`, `out_inst` and `out_pc` hold.

## Timing
- `imem_addr` is combinational from the `pc` register; no memory latency is added.
- `start` sampled at edge N: state becomes FETCH after N. First capture at edge N+1, so `out_valid`=1 holding address 0 after N+1.
- Throughput with `out_ready` held high: one instruction per cycle.
- `redirect` at edge N: `out_valid`=0 after N. Target instruction is valid after N+1 (one bubble).
- Capture and consume in the same cycle: `out_valid` stays 1 with the new data; no bubble.
- Asserting `rst` mid-stream clears all state immediately, independent of `clk`.

## Configuration
- `INST_FETCH_HALT_EN` defined:
  - A capture whose `imem_inst` equals `HALT_OPCODE` (8'hFF) is presented downstream normally (`out_valid`=1).
  - On that capture, `pc` does not increment and state←HALTED.
  - In HALTED the pending instruction drains through the handshake; no further captures.
  - HALTED exits only via `start`, `redirect` or `rst`.
- Not defined: no opcode is special, state HALTED is unreachable, and `halted` is tied to 0.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_W`, `INST_W`, `HALT_OPCODE`.
  - Fetch state enum: IDLE, FETCH, HALTED.
- One sub-module, `fetch_pc`: PC register with load (start/redirect), increment enable, and wrap.
- Output register, handshake and FSM live in `inst_fetch`.
- Instruction memory stays a separate module and is connected at the top level.

## Test plan
Bench memory contents: 00,55,AA,FF,0F,5A,A5,F0.
- Reset, then `start` with `out_ready`=1, macro undefined → `out_inst` sequence 00,55,AA,FF,0F,5A,A5,F0,00 on consecutive cycles; `out_pc` 0..7 then 0 (wrap).
- Same stimulus with `INST_FETCH_HALT_EN` → 00,55,AA,FF delivered, then `halted`=1 and `out_valid`=0 after the FF is consumed; `imem_addr` stays 3.
- `out_ready`=0 for 3 cycles while `out_inst`=55 → `out_inst`/`out_pc`/`imem_addr` hold at 55/1/2; after release, the next instruction is AA.
- `redirect`=1, `redirect_pc`=5 while `out_inst`=AA is valid → flush (`out_valid`=0) for 1 cycle, then 5A at `out_pc`=5.
- `start` and `redirect` (target 6) in the same cycle → fetch resumes at 00/`out_pc`=0.
- `rst` asserted between clock edges while `out_valid`=1 → all outputs are at reset values immediately; after release, no fetch until `start`.
